wash_cycle_ctrl: RTL

//  Parametrised washing-machine sequencer: load sizing, wash, rinse, dry, done.

---
 rtl/wash_pkg.sv | 22 ++
 rtl/wash_phase_timer.sv | 37 +++
 rtl/wash_cycle_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared types and defaults for the washing-machine sequencer.
// The state encoding doubles as the PHASE debug output.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_DRY   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int PHASE_W          = 3;
    localparam int DEF_TIMER_W      = 12;
    localparam int DEF_WASH_TICKS   = 3600;
    localparam int DEF_RINSE_TICKS  = 1800;
    localparam int DEF_DRY_TICKS    = 2400;
    localparam int DEF_MAX_REWASH   = 2;
    localparam int DEF_MAX_REDRY    = 2;

endpackage

// File: rtl/wash_phase_timer.sv
// Shared down-counting phase timer: reloaded on each phase entry,
// `last` flags the final cycle of the phase (count reached zero).
module wash_phase_timer #(
    parameter int TIMER_W = 12
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             load,
    input  logic [TIMER_W:0] load_val,
    output logic             last
);

    localparam logic [TIMER_W:0] ONE = {{TIMER_W{1'b0}}, 1'b1};

    logic [TIMER_W:0] cnt_q;
    logic [TIMER_W:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer: load sizing, wash, rinse, dry, done with
// bounded rewash/redry retries, level-sensitive abort on START low.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int TIMER_W     = DEF_TIMER_W,
    parameter int WASH_TICKS  = DEF_WASH_TICKS,
    parameter int RINSE_TICKS = DEF_RINSE_TICKS,
    parameter int DRY_TICKS   = DEF_DRY_TICKS,
    parameter int MAX_REWASH  = DEF_MAX_REWASH,
    parameter int MAX_REDRY   = DEF_MAX_REDRY
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               START,
    input  logic               MEDIUMIn,
    input  logic               LARGEIn,
    input  logic               DIRTY,
    input  logic               WET,
    output logic               MEDIUMOut,
    output logic               LARGEOut,
    output logic               WASH,
    output logic               RINSE,
    output logic               DRY,
    output logic               DONE,
    output logic [PHASE_W-1:0] PHASE
);

    // Timer holds ticks-1 so that a phase lasts exactly `ticks` cycles.
    localparam logic [TIMER_W:0] WASH_M_LD = (TIMER_W+1)'(WASH_TICKS - 1);
    localparam logic [TIMER_W:0] WASH_L_LD = (TIMER_W+1)'(2 * WASH_TICKS - 1);
    localparam logic [TIMER_W:0] RINSE_LD  = (TIMER_W+1)'(RINSE_TICKS - 1);
    localparam logic [TIMER_W:0] DRY_LD    = (TIMER_W+1)'(DRY_TICKS - 1);

    localparam int REW_W = (MAX_REWASH < 1) ? 1 : $clog2(MAX_REWASH + 1);
    localparam int RED_W = (MAX_REDRY < 1) ? 1 : $clog2(MAX_REDRY + 1);
    localparam logic [REW_W-1:0] REW_MAX = REW_W'(MAX_REWASH);
    localparam logic [RED_W-1:0] RED_MAX = RED_W'(MAX_REDRY);
    localparam logic [REW_W-1:0] REW_ONE = {{(REW_W-1){1'b0}}, 1'b1};
    localparam logic [RED_W-1:0] RED_ONE = {{(RED_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             medium_q, medium_d;
    logic             large_q, large_d;
    logic [REW_W-1:0] rewash_q, rewash_d;
    logic [RED_W-1:0] redry_q, redry_d;
    logic             tmr_load;
    logic [TIMER_W:0] tmr_val;
    logic             tmr_last;
    logic [TIMER_W:0] wash_ld;

    assign wash_ld = large_q ? WASH_L_LD : WASH_M_LD;

    wash_phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            medium_q <= 1'b0;
            large_q  <= 1'b0;
            rewash_q <= '0;
            redry_q  <= '0;
        end else begin
            state_q  <= state_d;
            medium_q <= medium_d;
            large_q  <= large_d;
            rewash_q <= rewash_d;
            redry_q  <= redry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        medium_d = medium_q;
        large_d  = large_q;
        rewash_d = rewash_q;
        redry_d  = redry_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!START) begin
            // Abort from any state; timer is forced back to zero as well.
            state_d  = ST_IDLE;
            medium_d = 1'b0;
            large_d  = 1'b0;
            rewash_d = '0;
            redry_d  = '0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (MEDIUMIn || LARGEIn) begin
                        state_d  = ST_LOAD;
                        large_d  = LARGEIn;
                        medium_d = MEDIUMIn && !LARGEIn;
                    end
                end
                ST_LOAD: begin
                    state_d  = ST_WASH;
                    tmr_load = 1'b1;
                    tmr_val  = wash_ld;
                end
                ST_WASH: begin
                    if (tmr_last) begin
                        state_d  = ST_RINSE;
                        tmr_load = 1'b1;
                        tmr_val  = RINSE_LD;
                    end
                end
                ST_RINSE: begin
                    if (tmr_last) begin
                        tmr_load = 1'b1;
                        if (DIRTY && (rewash_q < REW_MAX)) begin
                            rewash_d = rewash_q + REW_ONE;
                            state_d  = ST_WASH;
                            tmr_val  = wash_ld;
                        end else begin
                            state_d  = ST_DRY;
                            tmr_val  = DRY_LD;
                        end
                    end
                end
                ST_DRY: begin
                    if (tmr_last) begin
                        if (WET && (redry_q < RED_MAX)) begin
                            redry_d  = redry_q + RED_ONE;
                            tmr_load = 1'b1;
                            tmr_val  = DRY_LD;
                        end else begin
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        PHASE     = state_q;
        MEDIUMOut = medium_q;
        LARGEOut  = large_q;
        WASH      = (state_q == ST_WASH);
        RINSE     = (state_q == ST_RINSE);
        DRY       = (state_q == ST_DRY);
        DONE      = (state_q == ST_DONE);
    end

endmodule
